// File: rtl/img_ram_pingpong.sv
// Double-buffered image RAM: wide strobed writes into the back bank, narrow
// registered lane reads from the front bank, bank exchange on swap.
module img_ram_pingpong #(
  parameter int WW        = 128,
  parameter int RW        = 8,
  parameter int WDEPTH    = 256,
  parameter int LSB_FIRST = 1,
  localparam int NL       = WW / RW,
  localparam int LW       = $clog2(NL),
  localparam int AWW      = $clog2(WDEPTH),
  localparam int AWR      = AWW + LW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [WW-1:0]  dw,
  input  logic [NL-1:0]  wstrb,
  input  logic [AWW-1:0] addr_w,
  input  logic           write,
  input  logic           read,
  input  logic [AWR-1:0] addr_r,
  output logic [RW-1:0]  dr,
  output logic           dr_valid,
  input  logic           swap,
  output logic           rd_bank,
  output logic [7:0]     frame_cnt
);

  logic [WW-1:0] mem [2*WDEPTH];

  logic          rd_bank_q, rd_bank_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [WW-1:0] rdata_q;
  logic [LW-1:0] lane_q;
  logic          valid_q;
  logic [LW-1:0] physLane;

  // Logical lane i lives at physical slice lanePos(i) of the stored word.
  function automatic int lanePos(input int i);
    return (LSB_FIRST != 0) ? i : (NL - 1 - i);
  endfunction

  always_comb begin
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    if (swap) begin
      rd_bank_d   = ~rd_bank_q;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      rd_bank_q   <= rd_bank_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Storage is never reset; writes target the bank that is back at this edge.
  always_ff @(posedge clk) begin
    if (write && !reset) begin
      for (int i = 0; i < NL; i++) begin
        if (wstrb[i]) begin
          mem[{~rd_bank_q, addr_w}][lanePos(i)*RW +: RW] <= dw[lanePos(i)*RW +: RW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= read;
      if (read) begin
        rdata_q <= mem[{rd_bank_q, addr_r[AWR-1:LW]}];
        lane_q  <= addr_r[LW-1:0];
      end
    end
  end

  // With a power-of-two lane count, NL-1-x is simply the bitwise inverse.
  assign physLane = (LSB_FIRST != 0) ? lane_q : ~lane_q;

  always_comb begin
    dr = '0;
    for (int i = 0; i < NL; i++) begin
      if (physLane == LW'(i)) dr = rdata_q[i*RW +: RW];
    end
  end

  assign dr_valid  = valid_q;
  assign rd_bank   = rd_bank_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_img_ram_pingpong.sv
// Directed scoreboard bench driving an LSB_FIRST=1 and an LSB_FIRST=0 instance
// in lockstep against a per-bank word model.
module tb_img_ram_pingpong;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] dw;
  logic [15:0]  wstrb;
  logic [7:0]   addr_w;
  logic         write;
  logic         read;
  logic [11:0]  addr_r;
  logic         swap;
  logic [7:0]   dr1, dr0;
  logic         drValid1, drValid0;
  logic         rdBank1, rdBank0;
  logic [7:0]   frameCnt1, frameCnt0;

  int nAsserts = 0;
  int nFails   = 0;

  logic [127:0] mdl1 [2][256];
  logic [127:0] mdl0 [2][256];
  logic         mBank;
  logic [7:0]   mCnt;
  logic [15:0]  lastDr;
  logic [15:0]  expQ [$];

  always #5 clk = ~clk;

  img_ram_pingpong #(.WW(128), .RW(8), .WDEPTH(256), .LSB_FIRST(1)) dutLsb1 (
    .clk(clk), .reset(reset), .dw(dw), .wstrb(wstrb), .addr_w(addr_w),
    .write(write), .read(read), .addr_r(addr_r), .dr(dr1), .dr_valid(drValid1),
    .swap(swap), .rd_bank(rdBank1), .frame_cnt(frameCnt1));

  img_ram_pingpong #(.WW(128), .RW(8), .WDEPTH(256), .LSB_FIRST(0)) dutLsb0 (
    .clk(clk), .reset(reset), .dw(dw), .wstrb(wstrb), .addr_w(addr_w),
    .write(write), .read(read), .addr_r(addr_r), .dr(dr0), .dr_valid(drValid0),
    .swap(swap), .rd_bank(rdBank0), .frame_cnt(frameCnt0));

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic expRead, input logic wasReset);
    logic [15:0] e;
    checkEq("rd_bank1", 32'(rdBank1), 32'(mBank));
    checkEq("frame_cnt1", 32'(frameCnt1), 32'(mCnt));
    checkEq("rd_bank0", 32'(rdBank0), 32'(mBank));
    checkEq("frame_cnt0", 32'(frameCnt0), 32'(mCnt));
    if (expRead) begin
      e = expQ.pop_front();
      lastDr = e;
      checkEq("dr_valid1", 32'(drValid1), 32'd1);
      checkEq("dr_valid0", 32'(drValid0), 32'd1);
    end else begin
      if (wasReset) lastDr = 16'h0000;
      checkEq("dr_valid1_idle", 32'(drValid1), 32'd0);
      checkEq("dr_valid0_idle", 32'(drValid0), 32'd0);
    end
    checkEq("dr_lsb1", 32'(dr1), 32'(lastDr[15:8]));
    checkEq("dr_lsb0", 32'(dr0), 32'(lastDr[7:0]));
  endtask

  // One clock: drive, predict reads from pre-edge state, update model, check.
  task automatic applyStimulus(input logic rst, input logic wr, input logic [15:0] strb,
                               input logic [7:0] aw, input logic [127:0] d,
                               input logic rd, input logic [11:0] ar, input logic sw);
    logic       expRead;
    logic [7:0] w;
    int         ln;
    reset = rst; write = wr; wstrb = strb; addr_w = aw; dw = d;
    read = rd; addr_r = ar; swap = sw;
    expRead = rd && !rst;
    if (expRead) begin
      w  = ar[11:4];
      ln = int'(ar[3:0]);
      expQ.push_back({mdl1[mBank][w][ln*8 +: 8], mdl0[mBank][w][(15-ln)*8 +: 8]});
    end
    @(posedge clk);
    if (rst) begin
      mBank = 1'b0;
      mCnt  = 8'd0;
    end else begin
      if (wr) begin
        for (int i = 0; i < 16; i++) begin
          if (strb[i]) begin
            mdl1[~mBank][aw][i*8 +: 8]      = d[i*8 +: 8];
            mdl0[~mBank][aw][(15-i)*8 +: 8] = d[(15-i)*8 +: 8];
          end
        end
      end
      if (sw) begin
        mBank = ~mBank;
        mCnt  = mCnt + 8'd1;
      end
    end
    #1;
    checkOutput(expRead, rst);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 16'h0, 8'd0, 128'h0, 1'b0, 12'd0, 1'b0);
  endtask

  task automatic readWord(input logic [7:0] w, input int first, input int last);
    for (int ln = first; ln <= last; ln++)
      applyStimulus(1'b0, 1'b0, 16'h0, 8'd0, 128'h0, 1'b1, {w, 4'(ln)}, 1'b0);
  endtask

  initial begin
    logic [127:0] rnd;
    mBank  = 1'b0;
    mCnt   = 8'd0;
    lastDr = 16'h0;

    applyStimulus(1'b1, 1'b0, 16'h0, 8'd0, 128'h0, 1'b0, 12'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 8'd0, 128'h0, 1'b0, 12'd0, 1'b0);

    // Ramp frame into the back bank, publish it, read all lanes back to back.
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 8'd0, 128'h0F0E0D0C0B0A09080706050403020100,
                  1'b0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'd0, 128'h0, 1'b0, 12'd0, 1'b1);
    readWord(8'd0, 0, 15);
    idle();
    idle();

    // Back-bank write must not disturb the displayed frame.
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 8'd0, {16{8'hAA}}, 1'b0, 12'd0, 1'b0);
    readWord(8'd0, 0, 15);

    // Partial strobes over an all-0x11 word.
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 8'd3, {16{8'h11}}, 1'b0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0005, 8'd3, {16{8'h55}}, 1'b0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 8'd3, {16{8'hEE}}, 1'b0, 12'd0, 1'b1);
    readWord(8'd3, 0, 3);

    // Write and swap on one edge: new data visible on the very next read.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 8'd5, rnd, 1'b0, 12'd0, 1'b1);
    readWord(8'd5, 0, 15);

    // Read and swap on one edge: the read still sees the old front bank.
    applyStimulus(1'b0, 1'b0, 16'h0, 8'd0, 128'h0, 1'b1, {8'd5, 4'd2}, 1'b1);
    idle();

    for (int n = 0; n < 256; n++)
      applyStimulus(1'b0, 1'b0, 16'h0, 8'd0, 128'h0, 1'b0, 12'd0, 1'b1);
    idle();

    // Reset mid-burst with a write that would hit bank 0 if not suppressed.
    if (mBank == 1'b0) applyStimulus(1'b0, 1'b0, 16'h0, 8'd0, 128'h0, 1'b0, 12'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'd0, 128'h0, 1'b1, {8'd5, 4'd0}, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'd0, 128'h0, 1'b1, {8'd5, 4'd1}, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 8'd0, {16{8'h77}}, 1'b1, {8'd5, 4'd2}, 1'b1);
    readWord(8'd0, 0, 3);
    readWord(8'd3, 0, 3);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
